// File: rtl/u_seq_tm_pkg.sv
// ============================================================================
// Module      : u_seq_tm_pkg
// Description : Shared types and helpers for the sequential truncated multiplier
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package u_seq_tm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of shift-add steps for one transaction.
    function automatic int tm_steps(input int n, input int k, input logic trunc_en);
        return trunc_en ? (n - k) : n;
    endfunction

    function automatic logic [63:0] tm_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic trunc_en, input int k);
        logic [63:0] ah;
        logic [63:0] bh;
        ah = 64'(a >> k);
        bh = 64'(b >> k);
        return trunc_en ? ((ah * bh) << (2 * k)) : (64'(a) * 64'(b));
    endfunction

endpackage

`default_nettype wire

// File: rtl/u_seq_tm.sv
// ============================================================================
// Module      : u_seq_tm
// Description : Sequential unsigned truncated/exact multiplier, one shift-add
//               step per clock, valid/ready on both sides
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module u_seq_tm
    import u_seq_tm_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             trunc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   prod,
    output logic             busy
);

    localparam int              CW         = $clog2(N + 1);
    localparam logic [CW-1:0]   c_one      = CW'(1);
    localparam logic [N-1:0]    c_low_mask = N'((64'd1 << K) - 64'd1);

    state_t             r_state;
    state_t             w_state_next;
    logic [2*N-1:0]     r_acc;
    logic [2*N-1:0]     r_a_sh;
    logic [N-1:0]       r_b;
    logic [CW-1:0]      r_cnt;

    logic [N-1:0]       w_a_mask;
    logic [2*N-1:0]     w_a_ext;
    logic [2*N-1:0]     w_a_init;
    logic [N-1:0]       w_b_init;
    logic               w_accept;

    // Truncated mode drops a[K-1:0] and starts the walk at b[K], so the
    // multiplicand is pre-shifted to bit K to line up with the first kept b bit.
    assign w_a_mask = trunc_en ? (a & ~c_low_mask) : a;
    assign w_a_ext  = {{N{1'b0}}, w_a_mask};
    assign w_a_init = trunc_en ? (w_a_ext << K) : w_a_ext;
    assign w_b_init = trunc_en ? (b >> K) : b;
    assign w_accept = in_valid && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_state_next = CALC;
            CALC:    if (r_cnt == c_one)  w_state_next = DONE;
            DONE:    if (out_ready)       w_state_next = IDLE;
            default:                      w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_a_sh <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_acc  <= '0;
            r_a_sh <= w_a_init;
            r_b    <= w_b_init;
            r_cnt  <= CW'(tm_steps(N, K, trunc_en));
        end else if (r_state == CALC) begin
            if (r_b[0]) begin
                r_acc <= r_acc + r_a_sh;
            end
            r_a_sh <= r_a_sh << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt - c_one;
        end
    end

    assign prod = r_acc;

endmodule

`default_nettype wire

// File: doc/u_seq_tm.md
# u_seq_tm

Parametrised sequential unsigned truncated multiplier: one shift-add step per clock over the kept multiplier bits, with valid/ready handshakes on both sides. It is the clocked, handshaked successor to the fixed 8-bit combinational truncated multipliers in the approximate-arithmetic library. It is generalised in operand width and truncation column, and adds a per-transaction exact mode. It sits between an operand producer and a result consumer in accelerator datapaths that trade accuracy for area.

## Interface
- `N`, default 8: operand width, N ≥ 2.
- `K`, default 7: truncation column, 0 ≤ K ≤ N-1. Partial products a[i]&b[j] are kept only when i ≥ K and j ≥ K.
- `clk` input, 1: sole clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operands valid.
- `in_ready` output, 1: block can accept operands.
- `a` input, N: multiplicand, unsigned.
- `b` input, N: multiplier, unsigned.
- `trunc_en` input, 1: 1 = truncated product, 0 = exact product. Sampled with the operands.
- `out_valid` output, 1: `prod` is valid.
- `out_ready` input, 1: consumer accepts `prod`.
- `prod` output, 2N: result.
- `busy` output, 1: high in CALC or DONE.

## Operation
- FSM states are IDLE, CALC and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`&`in_ready`, latch `a`, `b` and `trunc_en`, clear the accumulator, load the step counter, and go to CALC.
- **Operand preparation at acceptance**
  - Truncated: bits a[K-1:0] are zeroed; iteration covers b[K..N-1], so L = N-K steps.
  - Exact: iteration covers b[0..N-1], so L = N steps.
- **CALC**
  - Each cycle, if the current b bit is 1, add the masked `a` shifted left by the bit index to the 2N-bit accumulator. Then advance the bit index and decrement the counter.
  - After the L-th step, go to DONE.
- **DONE**
  - `out_valid` = 1 and `prod` = accumulator.
  - On `out_valid`&`out_ready`, go to IDLE.
- **Arithmetic**
  - Truncated: `prod` = ((a>>K)*(b>>K)) << 2K, exactly.
  - Exact: `prod` = a*b.
  - Result is 2N bits; no overflow is possible.
  - With K=0, the truncated and exact results are equal.
- Inputs `a`, `b` and `trunc_en` are ignored outside the accepting cycle.
- `in_valid` without `in_ready` is allowed. It is simply not accepted.
- `prod` is held stable for as long as `out_valid`=1 and `out_ready`=0.

## Timing
- **Reset**
  - `rst_n` low asynchronously forces IDLE: `out_valid`=0, `prod`=0, `busy`=0, and `in_ready`=1 while reset is held.
  - Reset mid-CALC or mid-DONE discards the transaction; no `out_valid` is produced for it.
- **Latency**
  - If the acceptance edge is T, `out_valid` rises at edge T+L.
  - L = N-K for truncated and N for exact. N=8, K=7 truncated gives latency 1.
- **Handshake**
  - `in_ready` is low from edge T until the edge after the output handshake completes.
  - There is no same-cycle input acceptance during DONE and no bypass. Throughput is one result per L+1 cycles when `out_ready` is tied high.
- Simultaneous `out_ready` and `in_valid` in DONE: the output completes; the input is accepted no earlier than the following cycle in IDLE.
- `out_ready` asserted before `out_valid` has no effect.

## Structure
- Shared package `u_seq_tm_pkg` contains:
  - the state enum (IDLE, CALC, DONE);
  - a function computing the step count L from N, K and `trunc_en`;
  - a reference function `tm_ref(a, b, trunc_en)` used by the bench.
- Single module. The datapath (accumulator, shifted-operand register, counter) is too small for a sub-module to be worthwhile.
- The counter is $clog2(N+1) bits wide.

## Test plan
- **N=8, K=7, truncated**, a=0x80, b=0x80: `prod`=0x4000 with `out_valid` 1 cycle after acceptance. With a=0xFF, b=0xFF: `prod`=0x4000.
- **N=8, K=7, exact**, a=0xFF, b=0xFF: `prod`=0xFE01 with `out_valid` 8 cycles after acceptance. With a=0, b=0xFF: `prod`=0.
- **N=8, K=4, truncated**, a=0xFF, b=0xFF: `prod`=0xE100 after 4 cycles. With a=0x0F, b=0xFF: `prod`=0x0000.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles in DONE. `prod` and `out_valid` stay stable, `in_ready`=0, and new `in_valid` with different operands is ignored. Release `out_ready`: `in_ready`=1 on the next cycle.
- **Reset mid-CALC:** with N=8, K=0, pull `rst_n` low at step 3. Outputs go immediately to `out_valid`=0, `prod`=0, `in_ready`=1. The next transaction, a=3, b=5, returns 15.
- **Random regression:** 10k random a, b and `trunc_en` with random `out_ready` stalls, for N∈{4, 8, 16} and K∈{0, N/2, N-1}. Every `prod` must match `tm_ref`, and every latency must equal L.
